// File: rtl/fpu_except_pipe_if.sv
// Operand/result handshake bundle for fpu_except_pipe.
// master = operand producer and result consumer; slave = the classifier.
interface fpu_except_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int N_OPS  = 2
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic                 in_valid;
    logic                 in_ready;
    logic [N_OPS*W-1:0]   in_ops;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_OPS*6-1:0]   out_class;
    logic                 out_inf;
    logic                 out_ind;
    logic                 out_qnan;
    logic                 out_snan;
    logic                 out_nan;
    logic                 sticky_clr;
    logic                 sticky_invalid;
    logic                 sticky_denorm;

    modport master (
        output in_valid, in_ops, out_ready, sticky_clr,
        input  in_ready, out_valid, out_class, out_inf, out_ind,
               out_qnan, out_snan, out_nan, sticky_invalid, sticky_denorm
    );

    modport slave (
        input  in_valid, in_ops, out_ready, sticky_clr,
        output in_ready, out_valid, out_class, out_inf, out_ind,
               out_qnan, out_snan, out_nan, sticky_invalid, sticky_denorm
    );
endinterface

// File: rtl/fpu_except_pipe.sv
// Two-stage pipelined IEEE-754 operand classifier with valid/ready handshake
// and sticky invalid/denormal flags.
module fpu_except_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int N_OPS  = 2
) (
    input logic              clk,
    input logic              rst,
    fpu_except_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic adv;
    logic hs;

    // Field-level decodes of the incoming bundle
    logic [N_OPS-1:0] d_exp_ones;
    logic [N_OPS-1:0] d_exp_zero;
    logic [N_OPS-1:0] d_frac_zero;
    logic [N_OPS-1:0] d_frac_msb;
    logic [N_OPS-1:0] d_frac_low_nz;

    // Stage 1
    logic             s1_valid;
    logic [N_OPS-1:0] s1_exp_ones;
    logic [N_OPS-1:0] s1_exp_zero;
    logic [N_OPS-1:0] s1_frac_zero;
    logic [N_OPS-1:0] s1_frac_msb;
    logic [N_OPS-1:0] s1_frac_low_nz;

    // Classes derived from stage 1
    logic [N_OPS-1:0]   c_zero;
    logic [N_OPS-1:0]   c_denorm;
    logic [N_OPS-1:0]   c_normal;
    logic [N_OPS-1:0]   c_inf;
    logic [N_OPS-1:0]   c_qnan;
    logic [N_OPS-1:0]   c_snan;
    logic [N_OPS*6-1:0] cls;

    // Stage 2
    logic               s2_valid;
    logic [N_OPS*6-1:0] s2_class;
    logic               s2_inf;
    logic               s2_ind;
    logic               s2_qnan;
    logic               s2_snan;
    logic               s2_denorm_any;

    logic st_invalid;
    logic st_denorm;

    assign adv = ~s2_valid | bus.out_ready;
    assign hs  = s2_valid & bus.out_ready;

    genvar k;
    generate
        for (k = 0; k < N_OPS; k++) begin : g_op
            assign d_exp_ones[k]    = &bus.in_ops[k*W+FRAC_W +: EXP_W];
            assign d_exp_zero[k]    = ~|bus.in_ops[k*W+FRAC_W +: EXP_W];
            assign d_frac_zero[k]   = ~|bus.in_ops[k*W +: FRAC_W];
            assign d_frac_msb[k]    = bus.in_ops[k*W+FRAC_W-1];
            assign d_frac_low_nz[k] = |bus.in_ops[k*W +: FRAC_W-1];

            assign c_zero[k]   = s1_exp_zero[k] & s1_frac_zero[k];
            assign c_denorm[k] = s1_exp_zero[k] & ~s1_frac_zero[k];
            assign c_normal[k] = ~s1_exp_zero[k] & ~s1_exp_ones[k];
            assign c_inf[k]    = s1_exp_ones[k] & s1_frac_zero[k];
            assign c_qnan[k]   = s1_exp_ones[k] & s1_frac_msb[k];
            assign c_snan[k]   = s1_exp_ones[k] & ~s1_frac_msb[k] & s1_frac_low_nz[k];

            assign cls[k*6 +: 6] = {c_snan[k], c_qnan[k], c_inf[k],
                                    c_normal[k], c_denorm[k], c_zero[k]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_exp_ones    <= '0;
            s1_exp_zero    <= '0;
            s1_frac_zero   <= '0;
            s1_frac_msb    <= '0;
            s1_frac_low_nz <= '0;
        end else if (adv) begin
            s1_valid       <= bus.in_valid;
            s1_exp_ones    <= d_exp_ones;
            s1_exp_zero    <= d_exp_zero;
            s1_frac_zero   <= d_frac_zero;
            s1_frac_msb    <= d_frac_msb;
            s1_frac_low_nz <= d_frac_low_nz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_class <= '0;
            s2_inf   <= 1'b0;
            s2_ind   <= 1'b0;
            s2_qnan  <= 1'b0;
            s2_snan  <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_class <= cls;
            s2_inf   <= |c_inf;
            s2_ind   <= &c_inf;
            s2_qnan  <= |c_qnan;
            s2_snan  <= |c_snan;
        end
    end

    always_comb begin
        s2_denorm_any = 1'b0;
        for (int unsigned i = 0; i < N_OPS; i++) begin
            s2_denorm_any = s2_denorm_any | s2_class[i*6+1];
        end
    end

    // Clear is applied before the current delivery is merged in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_invalid <= 1'b0;
            st_denorm  <= 1'b0;
        end else begin
            st_invalid <= (st_invalid & ~bus.sticky_clr) | (hs & (s2_snan | s2_ind));
            st_denorm  <= (st_denorm & ~bus.sticky_clr) | (hs & s2_denorm_any);
        end
    end

    assign bus.in_ready       = adv;
    assign bus.out_valid      = s2_valid;
    assign bus.out_class      = s2_class;
    assign bus.out_inf        = s2_inf;
    assign bus.out_ind        = s2_ind;
    assign bus.out_qnan       = s2_qnan;
    assign bus.out_snan       = s2_snan;
    assign bus.out_nan        = s2_qnan | s2_snan;
    assign bus.sticky_invalid = st_invalid;
    assign bus.sticky_denorm  = st_denorm;
endmodule
